instr_fetch: RTL and testbench

- Instruction fetch sequencer; the producer side of the instruction stream that the Control decoder consumes.
- Owns the program counter and issues read requests to instruction memory over a req/ack handshake.
- Presents each fetched instruction to decode over a valid/ready handshake.
- Applies the branch outcome returned by the datapath and halts on a dedicated HALT opcode.

---
 rtl/instr_fetch.sv | 168 ++++++++++++++++
 tb/tb_instr_fetch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch sequencer.
// Owns the program counter, reads instruction memory over a req/ack handshake
// and hands each instruction to decode over a valid/ready handshake. The PC is
// redirected on a taken branch and fetching stops on HALT_OP.
// Optional feature macro: IFETCH_STATS_EN adds the RetireCount and StallCount
// outputs.
module instr_fetch #(
  parameter int                 PC_W    = 10,
  parameter int                 INSTR_W = 9,
  parameter logic [INSTR_W-1:0] HALT_OP = 9'h1FF
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               Start,
  input  logic [PC_W-1:0]    StartAddr,
  output logic               ImReq,
  output logic [PC_W-1:0]    ImAddr,
  input  logic               ImAck,
  input  logic [INSTR_W-1:0] ImData,
  output logic [INSTR_W-1:0] Instr,
  output logic               InstrValid,
  input  logic               InstrReady,
  input  logic               BranchTaken,
  input  logic [PC_W-1:0]    Target,
  output logic [PC_W-1:0]    PC,
  output logic               Done
`ifdef IFETCH_STATS_EN
  ,
  output logic [31:0]        RetireCount,
  output logic [31:0]        StallCount
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_e;

  state_e               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic                 im_req_q, im_req_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 done_q, done_d;

  logic consume;
  logic is_halt;
  logic start_ok;

  assign consume  = instr_valid_q & InstrReady;
  assign is_halt  = (instr_q == HALT_OP);
  assign start_ok = Start & ((state_q == IDLE) | (state_q == HALTED));

  // State register; reset parks the sequencer in IDLE
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: Start only matters when not busy, ack ends FETCH, consume ends HOLD
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = FETCH;
      FETCH:   if (ImAck) state_d = HOLD;
      HOLD:    if (consume) state_d = is_halt ? HALTED : FETCH;
      HALTED:  if (Start) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  // Next values of PC, request, held instruction and Done for each state
  always_comb begin
    pc_d          = pc_q;
    im_req_d      = im_req_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    done_d        = done_q;
    case (state_q)
      IDLE, HALTED: begin
        if (Start) begin
          pc_d     = StartAddr;
          im_req_d = 1'b1;
          done_d   = 1'b0;
        end
      end
      FETCH: begin
        if (ImAck) begin
          instr_d       = ImData;
          instr_valid_d = 1'b1;
          im_req_d      = 1'b0;
        end
      end
      HOLD: begin
        if (consume) begin
          instr_valid_d = 1'b0;
          if (is_halt) begin
            done_d = 1'b1;
          end else begin
            im_req_d = 1'b1;
            pc_d     = BranchTaken ? Target : (pc_q + PC_W'(1));
          end
        end
      end
      default: begin
        im_req_d      = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  // Registered outputs; reset drops the request immediately
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q          <= '0;
      im_req_q      <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      im_req_q      <= im_req_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      done_q        <= done_d;
    end
  end

  assign ImReq      = im_req_q;
  assign ImAddr     = pc_q;
  assign PC         = pc_q;
  assign Instr      = instr_q;
  assign InstrValid = instr_valid_q;
  assign Done       = done_q;

`ifdef IFETCH_STATS_EN
  logic [31:0] retire_q, retire_d;
  logic [31:0] stall_q, stall_d;

  // Retired instructions (HALT included) and memory wait cycles since last Start
  always_comb begin
    retire_d = retire_q;
    stall_d  = stall_q;
    if (start_ok) begin
      retire_d = '0;
      stall_d  = '0;
    end else begin
      if (consume) retire_d = retire_q + 32'd1;
      if ((state_q == FETCH) && !ImAck) stall_d = stall_q + 32'd1;
    end
  end

  // Statistics counter registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      retire_q <= '0;
      stall_q  <= '0;
    end else begin
      retire_q <= retire_d;
      stall_q  <= stall_d;
    end
  end

  assign RetireCount = retire_q;
  assign StallCount  = stall_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch.
// The driver acts as instruction memory and decoder; a transaction-level model
// predicts each fetch address/instruction and queues it for the monitor.
module tb_instr_fetch;
  localparam int PC_W = 10;
  localparam int INSTR_W = 9;
  localparam logic [INSTR_W-1:0] HALT = 9'h1FF;

  logic               Clk, Reset_n, Start, ImReq, ImAck, InstrValid, InstrReady, BranchTaken, Done;
  logic [PC_W-1:0]    StartAddr, ImAddr, Target, PC;
  logic [INSTR_W-1:0] ImData, Instr;
`ifdef IFETCH_STATS_EN
  logic [31:0]        RetireCount, StallCount;
`endif

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .HALT_OP(HALT)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
    .ImReq(ImReq), .ImAddr(ImAddr), .ImAck(ImAck), .ImData(ImData),
    .Instr(Instr), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .BranchTaken(BranchTaken), .Target(Target), .PC(PC), .Done(Done)
`ifdef IFETCH_STATS_EN
    , .RetireCount(RetireCount), .StallCount(StallCount)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct { logic [PC_W-1:0] addr; logic [INSTR_W-1:0] instr; } exp_t;
  typedef struct { bit br; logic [PC_W-1:0] tgt; } plan_t;
  typedef enum { M_IDLE, M_BUSY, M_HALTED } mstate_e;

  logic [INSTR_W-1:0] mem [0:(1<<PC_W)-1];
  exp_t    expQ[$];
  plan_t   planQ[$];
  exp_t    cur;
  mstate_e m_state;
  logic [PC_W-1:0]    m_addr;
  logic [INSTR_W-1:0] m_instr;
  bit      m_done;
  int      m_retire, m_stall;
  int      vectors, miscompares, pops;
  bit      mon_en, prevValid;

  int latMin, latMax, readyPct, readyDelay, branchPct, startPct, ackNoisePct;
  int memWait, curLat, holdCnt;
  bit startPending;
  logic [PC_W-1:0] startAddrReq;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0h, required %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input logic [PC_W-1:0] a);
    m_addr  = a;
    m_instr = mem[a];
    expQ.push_back('{a, m_instr});
  endtask

  // Architectural rule for one consumed instruction
  task automatic modelConsume();
    plan_t p;
    if (planQ.size() > 0) p = planQ.pop_front();
    else begin
      p.br  = ($urandom_range(99, 0) < branchPct);
      p.tgt = PC_W'($urandom);
    end
    BranchTaken = p.br;
    Target      = p.tgt;
    m_retire++;
    if (m_instr == HALT) begin
      m_state = M_HALTED;
      m_done  = 1'b1;
    end else if (p.br) pushExp(p.tgt);
    else pushExp(m_addr + PC_W'(1));
  endtask

  // One negedge per cycle: start control, memory responder, decoder
  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(negedge Clk);
      Start = 1'b0;
      StartAddr = PC_W'($urandom);
      if (m_state != M_BUSY) begin
        if (startPending) begin
          Start = 1'b1;
          StartAddr = startAddrReq;
          startPending = 1'b0;
          m_state = M_BUSY;
          m_done = 1'b0;
          m_retire = 0;
          m_stall = 0;
          pushExp(startAddrReq);
        end
      end else if ($urandom_range(99, 0) < startPct) Start = 1'b1;

      if (ImReq) begin
        if (memWait >= curLat) begin
          ImAck = 1'b1;
          ImData = mem[ImAddr];
        end else begin
          ImAck = 1'b0;
          ImData = INSTR_W'($urandom);
          memWait++;
          m_stall++;
        end
      end else begin
        memWait = 0;
        curLat = $urandom_range(latMax, latMin);
        ImAck = ($urandom_range(99, 0) < ackNoisePct);
        ImData = INSTR_W'($urandom);
      end

      BranchTaken = 1'($urandom);
      Target = PC_W'($urandom);
      if (InstrValid) begin
        holdCnt++;
        InstrReady = (holdCnt > readyDelay) && ($urandom_range(99, 0) < readyPct);
        if (InstrReady) begin
          holdCnt = 0;
          modelConsume();
        end
      end else begin
        holdCnt = 0;
        InstrReady = 1'($urandom);
      end
    end
  endtask

  // Monitor: compares DUT against queued expectations away from the clock edge
  initial begin
    forever begin
      @(posedge Clk);
      #2;
      if (!mon_en) prevValid = 1'b0;
      else begin
        checkOutput("done", 32'(Done), 32'(m_done));
        checkOutput("req_valid_excl", 32'(ImReq & InstrValid), 32'd0);
        if (ImReq) begin
          checkOutput("req_expected", 32'(expQ.size() > 0), 32'd1);
          if (expQ.size() > 0) begin
            checkOutput("im_addr", 32'(ImAddr), 32'(expQ[0].addr));
            checkOutput("pc_fetch", 32'(PC), 32'(expQ[0].addr));
          end
        end
        if (InstrValid && !prevValid) begin
          checkOutput("valid_expected", 32'(expQ.size() > 0), 32'd1);
          if (expQ.size() > 0) begin
            cur = expQ.pop_front();
            pops++;
            checkOutput("instr", 32'(Instr), 32'(cur.instr));
            checkOutput("pc_hold", 32'(PC), 32'(cur.addr));
          end
        end else if (InstrValid) begin
          checkOutput("instr_stable", 32'(Instr), 32'(cur.instr));
          checkOutput("pc_stable", 32'(PC), 32'(cur.addr));
        end
        prevValid = InstrValid;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    vectors = 0; miscompares = 0; pops = 0;
    mon_en = 1'b0; prevValid = 1'b0;
    m_state = M_IDLE; m_done = 1'b0; m_retire = 0; m_stall = 0; m_addr = '0; m_instr = '0;
    memWait = 0; curLat = 0; holdCnt = 0; startPending = 1'b0; startAddrReq = '0;
    for (int i = 0; i < (1 << PC_W); i++) mem[i] = INSTR_W'($urandom_range(32'h1FE, 0));
    Reset_n = 1'b0; Start = 1'b0; StartAddr = '0; ImAck = 1'b0; ImData = '0;
    InstrReady = 1'b0; BranchTaken = 1'b0; Target = '0;

    repeat (3) @(negedge Clk);
    checkOutput("reset_imreq", 32'(ImReq), 32'd0);
    checkOutput("reset_valid", 32'(InstrValid), 32'd0);
    checkOutput("reset_pc", 32'(PC), 32'd0);
    checkOutput("reset_instr", 32'(Instr), 32'd0);
    checkOutput("reset_done", 32'(Done), 32'd0);
    Reset_n = 1'b1;
    mon_en = 1'b1;

    // Zero-wait memory, always-ready decoder, sequential from 5
    latMin = 0; latMax = 0; readyPct = 100; readyDelay = 0;
    branchPct = 0; startPct = 0; ackNoisePct = 0;
    startPending = 1'b1; startAddrReq = PC_W'(5);
    applyStimulus(2);
    p0 = pops;
    applyStimulus(20);
    checkOutput("throughput", 32'(pops - p0), 32'd10);

    // Slow memory and a decoder that stalls four cycles
    latMin = 3; latMax = 3; readyDelay = 4; ackNoisePct = 20;
    applyStimulus(40);

    // Taken branch at 12 to 3, then wrap from 1023 to 0
    latMin = 0; latMax = 2; readyDelay = 0;
    planQ.push_back('{1'b1, PC_W'(12)});
    planQ.push_back('{1'b1, PC_W'(3)});
    planQ.push_back('{1'b1, PC_W'(1023)});
    planQ.push_back('{1'b0, PC_W'(0)});
    applyStimulus(40);

    // Randomized traffic
    latMin = 0; latMax = 4; readyPct = 60; branchPct = 30; startPct = 10; ackNoisePct = 15;
    applyStimulus(1500);

    // HALT at 8, reached through 6,7,8 with a taken branch on the HALT itself
    readyPct = 100; startPct = 0;
    for (int i = 0; i < 20 && m_addr == PC_W'(8); i++) applyStimulus(1);
    mem[8] = HALT;
    planQ.delete();
    planQ.push_back('{1'b1, PC_W'(6)});
    planQ.push_back('{1'b0, PC_W'(0)});
    planQ.push_back('{1'b0, PC_W'(0)});
    planQ.push_back('{1'b1, PC_W'(500)});
    for (int i = 0; i < 300 && !Done; i++) applyStimulus(1);
    checkOutput("halt_reached", 32'(Done), 32'd1);
    applyStimulus(10);
    checkOutput("halted_no_req", 32'(ImReq), 32'd0);
    checkOutput("halted_done", 32'(Done), 32'd1);
`ifdef IFETCH_STATS_EN
    checkOutput("retire_count", RetireCount, 32'(m_retire));
    checkOutput("stall_count", StallCount, 32'(m_stall));
`endif
    mem[8] = INSTR_W'($urandom_range(32'h1FE, 0));
    startPending = 1'b1; startAddrReq = PC_W'(0);
    p0 = pops;
    applyStimulus(30);
    checkOutput("resumed_done", 32'(Done), 32'd0);
    checkOutput("resumed_progress", 32'(pops > p0), 32'd1);

    // Asynchronous reset in the middle of a fetch
    latMin = 6; latMax = 6;
    for (int i = 0; i < 50 && !(ImReq && !ImAck); i++) applyStimulus(1);
    checkOutput("reach_fetch", 32'(ImReq), 32'd1);
    @(posedge Clk);
    #3;
    mon_en = 1'b0;
    Reset_n = 1'b0;
    ImAck = 1'b1;
    ImData = INSTR_W'($urandom);
    #1;
    checkOutput("async_rst_imreq", 32'(ImReq), 32'd0);
    checkOutput("async_rst_valid", 32'(InstrValid), 32'd0);
    checkOutput("async_rst_pc", 32'(PC), 32'd0);
    repeat (2) @(negedge Clk);
    checkOutput("rst_ack_ignored", 32'(InstrValid), 32'd0);
    Reset_n = 1'b1;
    m_state = M_IDLE; m_done = 1'b0; m_retire = 0; m_stall = 0;
    expQ.delete(); planQ.delete();
    holdCnt = 0; memWait = 0; startPending = 1'b0;
    latMin = 0; latMax = 2; ackNoisePct = 50;
    mon_en = 1'b1;
    applyStimulus(5);
    checkOutput("idle_imreq", 32'(ImReq), 32'd0);
    checkOutput("idle_valid", 32'(InstrValid), 32'd0);
    checkOutput("idle_pc", 32'(PC), 32'd0);
    startPending = 1'b1; startAddrReq = PC_W'(20);
    applyStimulus(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
